// File: rtl/serial_bus_arbiter_if.sv
// Master/slave request and grant signals shared between the serial bus
// arbiter (slave modport) and the master/slave-port environment (master modport).
interface serial_bus_arbiter_if;
  logic [1:0] m_req;
  logic [1:0] m0_slave_sel;
  logic [1:0] m1_slave_sel;
  logic [2:0] s_ready;
  logic [2:0] s_done;
  logic [1:0] m_grant;
  logic       bus_owner;
  logic [2:0] s_select;
  logic       bus_busy;
  logic       timeout_err;
  logic       decode_err;

  modport slave (
    input  m_req, m0_slave_sel, m1_slave_sel, s_ready, s_done,
    output m_grant, bus_owner, s_select, bus_busy, timeout_err, decode_err
  );

  modport master (
    output m_req, m0_slave_sel, m1_slave_sel, s_ready, s_done,
    input  m_grant, bus_owner, s_select, bus_busy, timeout_err, decode_err
  );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for two bus masters over three slave ports; grants are
// held for one transaction and released on slave completion, abort or timeout.
module serial_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic [2:0]       select_q, select_d;
  logic             busy_q, busy_d;
  logic             tmo_q, tmo_d;
  logic             dec_q, dec_d;

  logic       winner;
  logic [1:0] win_sel;
  logic       done_hit, abort_hit, tmo_hit;

  // Slave readiness is handled by the masters themselves.
  wire unused_s_ready = ^bus.s_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      grant_q  <= '0;
      select_q <= '0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      dec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      dec_q    <= dec_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    select_d = select_q;
    busy_d   = busy_q;
    tmo_d    = 1'b0;
    dec_d    = 1'b0;

    winner    = (bus.m_req == 2'b11) ? prio_q : bus.m_req[1];
    win_sel   = winner ? bus.m1_slave_sel : bus.m0_slave_sel;
    // select_q holds the latched one-hot target, so only its own done counts.
    done_hit  = |(bus.s_done & select_q);
    abort_hit = ~bus.m_req[owner_q];
    tmo_hit   = (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        // The cycle after a decode rejection is skipped, so a retrying
        // invalid requester pulses decode_err every other cycle.
        if (!dec_q && (bus.m_req != 2'b00)) begin
          if (win_sel != 2'd3) begin
            state_d  = ST_GRANT;
            owner_d  = winner;
            grant_d  = 2'b01 << winner;
            select_d = 3'b001 << win_sel;
            busy_d   = 1'b1;
            cnt_d    = '0;
          end else begin
            dec_d  = 1'b1;
            prio_d = ~winner;
          end
        end
      end
      ST_GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done_hit || abort_hit || tmo_hit) begin
          state_d  = ST_RELEASE;
          grant_d  = '0;
          select_d = '0;
          tmo_d    = tmo_hit && !done_hit && !abort_hit;
        end
      end
      ST_RELEASE: begin
        prio_d  = ~owner_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        select_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign bus.m_grant     = grant_q;
  assign bus.bus_owner   = owner_q;
  assign bus.s_select    = select_q;
  assign bus.bus_busy    = busy_q;
  assign bus.timeout_err = tmo_q;
  assign bus.decode_err  = dec_q;

endmodule

// File: doc/serial_bus_arbiter.md
Name: serial_bus_arbiter

Overview:
Arbitrates the serial system bus between two masters and routes the winning master to one of three slave ports. Grants are round-robin and held for one full transaction, until the target slave reports completion, the owner withdraws its request, or a timeout expires. The block sits between the master request lines and the address/data/valid muxes feeding the slave input ports; it only controls those muxes and does not touch serial data.

Parameters:
TIMEOUT_CYCLES, 64, cycles a grant may stay in GRANT without s_done before forced release (legal range 2..255)
CNT_W, 8, width of timeout counter

Ports:
clk  input  1  bus clock, rising edge
reset  input  1  asynchronous, active-high reset
m_req  input  2  bit i = master i requests bus; held high until transaction ends
m0_slave_sel  input  2  target slave id for master 0 (0..2 valid, 3 invalid)
m1_slave_sel  input  2  target slave id for master 1
s_ready  input  3  slave_ready of each slave port (status only)
s_done  input  3  one-cycle completion pulse from each slave port
m_grant  output  2  one-hot grant to masters; 00 = none
bus_owner  output  1  index of current/last owner; drives master-side mux select
s_select  output  3  one-hot enable to target slave; 000 = none
bus_busy  output  1  high in GRANT and RELEASE
timeout_err  output  1  one-cycle pulse on timeout release
decode_err  output  1  one-cycle pulse on invalid slave id rejection

Behaviour:
- Reset is asynchronous, active-high, on signal reset; clock is clk. On reset all outputs are 0, state is IDLE, priority pointer prio = 0 (master 0 wins the first tie), timeout counter = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - Only m0 requests: winner 0. Only m1 requests: winner 1. Both request: winner = prio.
  - Winner's slave_sel latched into sel_reg.
  - sel_reg 0..2: next cycle m_grant = one-hot(winner), bus_owner = winner, s_select = one-hot(sel), bus_busy = 1, counter cleared, go to GRANT. Latency is 1 cycle from the sampled request to grant.
  - sel_reg = 3: no grant, decode_err pulses 1 cycle, prio = ~winner, stay in IDLE. A master still requesting with an invalid id is re-evaluated under the new prio, so it pulses again and alternates with a valid requester.
- GRANT:
  - Counter increments every cycle.
  - Release condition, first match wins:
    - (a) s_done[sel_reg] = 1 -> normal release.
    - (b) m_req[owner] = 0 -> abort release.
    - (c) counter = TIMEOUT_CYCLES-1 -> timeout release; timeout_err pulses in the cycle RELEASE is entered.
  - s_done on a non-selected slave is ignored.
  - s_ready is not used in the grant decision; the master performs the valid/ready handshake with the slave itself.
- RELEASE (exactly 1 cycle):
  - m_grant = 00, s_select = 000, bus_busy = 1, bus_owner holds.
  - prio = ~owner; then go to IDLE.
  - Minimum gap between consecutive grants is 2 cycles (RELEASE, then IDLE arbitration).
- Simultaneous events:
  - s_done and timeout in the same cycle -> normal release, no timeout_err.
  - A new request arriving during GRANT or RELEASE is only considered in IDLE.
  - A change to slave_sel during GRANT is ignored (sel_reg is latched).
- Reset mid-GRANT: grants and selects drop asynchronously and prio returns to 0. The slave port's own reset clears its partial capture.
- Invariants: m_grant and s_select are each at most one-hot; both are nonzero together or zero together.

Test Plan:
- m_req=01, m0_slave_sel=1 at cycle 0 -> cycle 1: m_grant=01, s_select=010, bus_busy=1. s_done=010 at cycle 22 -> cycle 23 RELEASE (m_grant=00), cycle 24 IDLE, bus_busy=0.
- m_req=11 from reset, both sel=0, each completes in 21 cycles -> grant order m0, m1, m0, m1; grants separated by 2 idle/release cycles.
- m_req=10, m1_slave_sel=2, never s_done -> m_grant=10 for exactly 64 cycles, then timeout_err pulse, m_grant=00, prio=0.
- m_req=01 with m0_slave_sel=3 -> decode_err pulses every other cycle, m_grant stays 00. With m1 also requesting sel=0, m1 is granted the following arbitration.
- Grant m0 to slave 0; pulse s_done=001 and reach timeout in the same cycle -> normal release, timeout_err=0. Pulse s_done=100 (wrong slave) -> no release.
- Assert reset at cycle 10 of a grant -> all outputs 0 immediately. After deassert, m_req=11 gives grant to m0 first.
